// File: rtl/cu_seq.sv
// Microcode sequencer for the jrb8 CPU: opcode fetch over SPI, up to STEPS micro-steps per
// instruction, SPI stalls for memory steps, PC update and interrupt entry at instruction end.
module cu_seq #(
    parameter int unsigned IR_W     = 8,
    parameter int unsigned PC_W     = 16,
    parameter int unsigned FLAG_W   = 22,
    parameter int unsigned STEPS    = 2,
    localparam int unsigned STEP_W  = (STEPS > 1) ? $clog2(STEPS) : 1,
    parameter int unsigned PCC_BIT  = 20,
    parameter int unsigned MEM_BITS [3] = '{13, 9, 10},
    parameter logic [FLAG_W-1:0] FETCH_FLAGS = FLAG_W'('h100200),
    parameter logic [PC_W-1:0]   RESET_PC    = '0,
    parameter logic [PC_W-1:0]   IRQ_VEC     = PC_W'('h0004)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt,
    input  logic                   spi_done,
    output logic                   spi_executing,
    input  logic [IR_W-1:0]        irin,
    output logic [IR_W+STEP_W-1:0] uop_addr,
    input  logic [FLAG_W:0]        uop_data,
    input  logic                   pcinflag,
    input  logic [PC_W-1:0]        pcin,
    input  logic                   irq,
    output logic                   irq_ack,
    output logic [PC_W-1:0]        epc,
    output logic [PC_W-1:0]        pc,
    output logic [STEP_W-1:0]      step,
    output logic                   highbits_we,
    output logic [FLAG_W-1:0]      flags_noc,
    output logic [FLAG_W-1:0]      flags,
    output logic [IR_W-1:0]        cuout
);

    typedef enum logic [2:0] {
        S_FETCH_SPI,
        S_LOAD_IR,
        S_ISSUE,
        S_STEP_SPI,
        S_EVENTS
    } state_e;

    function automatic logic [FLAG_W-1:0] mem_mask_f();
        logic [FLAG_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            m = m | (FLAG_W'(1) << MEM_BITS[i]);
        end
        return m;
    endfunction

    localparam logic [FLAG_W-1:0] MEM_MASK = mem_mask_f();

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PC_W-1:0]     epc_q, epc_d;
    logic                spi_q, spi_d;
    logic                irq_ack_q, irq_ack_d;

    logic [FLAG_W-1:0]   uflags;
    logic                last;
    logic                instr_end;
    logic [PC_W-1:0]     next_pc;

    assign uflags    = uop_data[FLAG_W-1:0];
    assign last      = uop_data[FLAG_W];
    assign instr_end = last || (step_q == STEP_W'(STEPS - 1));
    assign next_pc   = pcinflag ? pcin : pc_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        step_d    = step_q;
        epc_d     = epc_q;
        spi_d     = spi_q;
        irq_ack_d = 1'b0;
        flags_noc = uflags;
        flags     = '0;

        case (state_q)
            S_FETCH_SPI: begin
                flags_noc = FETCH_FLAGS;
                flags     = FETCH_FLAGS;
                if (spi_done) begin
                    spi_d   = 1'b0;
                    state_d = S_LOAD_IR;
                end else begin
                    spi_d = 1'b1;
                end
            end
            S_LOAD_IR: begin
                flags_noc = FETCH_FLAGS;
                flags     = FETCH_FLAGS;
                ir_d      = irin;
                step_d    = '0;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                if (uflags[PCC_BIT]) begin
                    pc_d = pc_q + 1'b1;
                end
                if (|(uflags & MEM_MASK)) begin
                    spi_d   = 1'b1;
                    state_d = S_STEP_SPI;
                end else begin
                    state_d = S_EVENTS;
                end
            end
            S_STEP_SPI: begin
                if (spi_done) begin
                    spi_d   = 1'b0;
                    state_d = S_EVENTS;
                end
            end
            S_EVENTS: begin
                flags = uflags;
                if (!instr_end) begin
                    step_d  = step_q + 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    // irq is only honoured here, so interrupt entry always lands on a boundary
                    if (irq) begin
                        epc_d     = next_pc;
                        pc_d      = IRQ_VEC;
                        irq_ack_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                    spi_d   = 1'b1;
                    state_d = S_FETCH_SPI;
                end
            end
            default: begin
                state_d = S_FETCH_SPI;
            end
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH_SPI;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            step_q    <= '0;
            epc_q     <= '0;
            spi_q     <= 1'b0;
            irq_ack_q <= 1'b0;
        end else if (!halt) begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            step_q    <= step_d;
            epc_q     <= epc_d;
            spi_q     <= spi_d;
            irq_ack_q <= irq_ack_d;
        end
    end

    assign uop_addr      = {ir_q, step_q};
    assign spi_executing = spi_q;
    assign irq_ack       = irq_ack_q;
    assign epc           = epc_q;
    assign pc            = pc_q;
    assign step          = step_q;
    assign cuout         = ir_q;
    assign highbits_we   = (state_q == S_EVENTS) && (step_q == '0);

endmodule

// File: doc/cu_seq.md
# cu_seq

Parametrised microcode sequencer, the next-generation control unit for the jrb8 CPU. It fetches an opcode over the SPI memory path and walks up to `STEPS` microcode steps per instruction, stalling on SPI for any step that touches ROM/RAM. It then advances or loads the PC and takes a pending interrupt at the instruction boundary. Microcode storage is external, read through `uop_addr`/`uop_data`; the sequencer has no internal ROM.

## Interface
- `IR_W`, 8: opcode width.
- `PC_W`, 16: program counter width.
- `FLAG_W`, 22: control-flag word width.
- `STEPS`, 2: maximum micro-steps per instruction (≥1); `STEP_W = max(1, clog2(STEPS))`.
- `PCC_BIT`, 20: PC-count flag index.
- `MEM_BITS`, {13,9,10}: flag indices (RAMI, ROMO, RAMO) that require an SPI transaction.
- `FETCH_FLAGS`, `22'h100200`: flags driven during fetch (PCC + ROMO).
- `RESET_PC`, 0: PC value after reset.
- `IRQ_VEC`, `16'h0004`: interrupt target address.

Ports:
- `clk` in 1: clock; all state updates on **negedge**.
- `rst` in 1: reset, asynchronous, active-high.
- `halt` in 1: freezes all state when high.
- `spi_done` in 1: SPI transaction complete.
- `spi_executing` out 1: SPI transaction request/busy.
- `irin` in IR_W: fetched opcode.
- `uop_addr` out IR_W+STEP_W: `{ir, step}`, combinational.
- `uop_data` in FLAG_W+1: combinational microcode word; bit FLAG_W = LAST.
- `pcinflag` in 1: load PC from `pcin` at instruction end.
- `pcin` in PC_W: jump target.
- `irq` in 1: level interrupt request.
- `irq_ack` out 1: one-cycle interrupt-taken pulse.
- `epc` out PC_W: saved return address.
- `pc` out PC_W: program counter.
- `step` out STEP_W: current micro-step.
- `highbits_we` out 1: high when state = EVENTS and step = 0.
- `flags_noc` out FLAG_W: flags without event gating.
- `flags` out FLAG_W: event-gated flags.
- `cuout` out IR_W: current IR.

## Operation
- **States:** FETCH_SPI, LOAD_IR, ISSUE, STEP_SPI, EVENTS.
- **Reset values:** state FETCH_SPI, `pc`=RESET_PC, `ir`=0, `step`=0, `epc`=0, `spi_executing`=0, `irq_ack`=0.
- **FETCH_SPI:**
  - Drives `spi_executing`<=1.
  - On `spi_done`: `spi_executing`<=0 and go to LOAD_IR.
  - `flags` = `flags_noc` = FETCH_FLAGS.
- **LOAD_IR:**
  - `ir`<=`irin`, `step`<=0, go to ISSUE.
  - `flags` = `flags_noc` = FETCH_FLAGS.
- **ISSUE:**
  - `flags_noc` = `uop_data[FLAG_W-1:0]`, `flags` = 0.
  - If the PCC bit is set: `pc`<=`pc`+1.
  - If any MEM_BITS bit is set: `spi_executing`<=1 and go to STEP_SPI; otherwise go to EVENTS.
- **STEP_SPI:**
  - `flags_noc` as in ISSUE, `flags` = 0.
  - On `spi_done`: `spi_executing`<=0 and go to EVENTS.
- **EVENTS:**
  - `flags` = `flags_noc` = microcode flags.
  - The instruction ends if LAST = 1 or `step` = STEPS-1.
    - Not ended: `step`<=`step`+1 and go to ISSUE.
    - Ended: compute `next` = `pcinflag` ? `pcin` : `pc`+1.
  - If `irq`: `epc`<=`next`, `pc`<=IRQ_VEC, `irq_ack`<=1 for one cycle. Otherwise `pc`<=`next`.
  - Then go to FETCH_SPI.
- **Arithmetic:** all PC arithmetic is modulo 2^PC_W; `pc` = all-ones +1 gives 0.
- **`irq` sampling:** sampled only at the EVENTS cycle that ends an instruction. Mid-instruction `irq` is ignored until that boundary. The requester holds `irq` until `irq_ack`.
- **PCC and jump together:** a PCC increment in ISSUE is followed by a `pcin` load at EVENTS; the load wins.
- **`halt`:** no register changes, including `spi_executing` and `irq_ack`. Combinational outputs track the frozen state.
- **`rst` mid-operation:** returns to reset values immediately, aborting any SPI wait. `rst` overrides `halt`.

## Timing
- `uop_addr` → `uop_data` is zero-latency combinational; `flags_noc` follows within the same cycle.
- Minimum instruction length, with no SPI steps and zero-latency `spi_done`: FETCH(1) + LOAD_IR(1) + 2 per step.
- Each SPI step adds cycles until `spi_done` is seen.
- `spi_executing` rises on the negedge entering a wait state and falls on the negedge where `spi_done` is sampled.
- `irq_ack` is high for exactly the one cycle following the ending EVENTS.

## Test plan
- **Reset:** assert `rst` mid-STEP_SPI → `pc`=0, `spi_executing`=0, state FETCH_SPI; `flags`=`22'h100200`.
- **Two-step instruction:** opcode `8'h12`, no mem bits, LAST=0 on step 0, `pcinflag`=0, `pc`=5 → steps 0 and 1 issued; `highbits_we` pulses once; `pc`=6.
- **Early end:** STEPS=4, step-0 word with LAST=1 → `uop_addr` never shows step 1; back to FETCH_SPI after one EVENTS.
- **SPI stall:** step with RAMO set, `spi_done` delayed 5 cycles → `flags`=0 throughout; `flags` asserted only in EVENTS after `spi_done`.
- **Jump with PCC:** PCC set in ISSUE, `pcinflag`=1, `pcin`=`16'h0100` → `pc`=`16'h0100`, not 0x0101.
- **Interrupt:** `irq` raised mid-instruction, `pc`=`16'hFFFF`, `pcinflag`=0 → at boundary `epc`=0, `pc`=`16'h0004`, single `irq_ack` pulse; `halt` held 3 cycles beforehand delays all of this by 3 cycles.
